// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a four-stage pipeline (fetch/decode/act/writeback).
// Produces the retain/clear controls of the i2d, d2a and a2w stage registers
// and the PC hold. It handles load-use hazards, multi-cycle d-cache accesses
// with a timeout, branch mispredicts, and halt/interrupt at writeback.
// The controls are combinational from the state and the inputs, and they take
// effect at the next clock edge.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int REG_ADDR_W  = 4,
  parameter int PERF_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  d_valid,
  input  logic                  d_rs_read,
  input  logic [REG_ADDR_W-1:0] d_rs_addr,
  input  logic                  a_valid,
  input  logic                  a_mem_load,
  input  logic                  a_mem_access,
  input  logic                  a_reg_write,
  input  logic [REG_ADDR_W-1:0] a_reg_addr,
  input  logic                  a_mispredict,
  input  logic                  dc_ready,
  input  logic                  w_valid,
  input  logic                  w_halt,
  input  logic                  w_interrupt,
  input  logic                  resume,
  output logic                  pc_retain,
  output logic                  i2d_retain,
  output logic                  i2d_clear,
  output logic                  d2a_retain,
  output logic                  d2a_clear,
  output logic                  a2w_retain,
  output logic                  a2w_clear,
  output logic                  halted,
  output logic                  mem_timeout_err,
  output logic [PERF_W-1:0]     stall_cycles
);

  localparam int TIMER_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALTED   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [PERF_W-1:0]  stall_q;

  logic w_event;
  logic mem_miss;
  logic load_use;
  logic run_rules;
  logic allow_miss;

  assign w_event  = w_valid & (w_halt | w_interrupt);
  assign mem_miss = a_valid & a_mem_access & ~dc_ready;
  assign load_use = d_valid & d_rs_read & a_valid & a_mem_load & a_reg_write
                    & (d_rs_addr == a_reg_addr);

  // Next-state and control decode; priority rules shared by RUN and MEM_WAIT completion
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_d         = state_q;
    timer_d         = timer_q;
    pc_retain       = 1'b0;
    i2d_retain      = 1'b0;
    i2d_clear       = 1'b0;
    d2a_retain      = 1'b0;
    d2a_clear       = 1'b0;
    a2w_retain      = 1'b0;
    a2w_clear       = 1'b0;
    halted          = 1'b0;
    mem_timeout_err = 1'b0;
    run_rules       = 1'b0;
    allow_miss      = 1'b0;

    if (rst) begin
      i2d_clear = 1'b1;
      d2a_clear = 1'b1;
      a2w_clear = 1'b1;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          run_rules  = 1'b1;
          allow_miss = 1'b1;
        end
        ST_MEM_WAIT: begin
          if (dc_ready) begin
            // The access completes: the stalled instructions move on this edge.
            run_rules = 1'b1;
            state_d   = ST_RUN;
            timer_d   = '0;
          end else if (timer_q < TIMER_MAX) begin
            pc_retain  = 1'b1;
            i2d_retain = 1'b1;
            d2a_retain = 1'b1;
            a2w_clear  = 1'b1;
            timer_d    = timer_q + TIMER_W'(1);
          end else begin
            // The d-cache never answered: flush the whole pipe and resume fetch.
            mem_timeout_err = 1'b1;
            i2d_clear       = 1'b1;
            d2a_clear       = 1'b1;
            a2w_clear       = 1'b1;
            state_d         = ST_RUN;
            timer_d         = '0;
          end
        end
        ST_HALTED: begin
          pc_retain = 1'b1;
          i2d_clear = 1'b1;
          d2a_clear = 1'b1;
          a2w_clear = 1'b1;
          halted    = 1'b1;
          if (resume) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase

      if (run_rules) begin
        if (w_event) begin
          i2d_clear = 1'b1;
          d2a_clear = 1'b1;
          a2w_clear = 1'b1;
          if (w_halt) state_d = ST_HALTED;
        end else if (allow_miss && mem_miss) begin
          pc_retain  = 1'b1;
          i2d_retain = 1'b1;
          d2a_retain = 1'b1;
          a2w_clear  = 1'b1;
          state_d    = ST_MEM_WAIT;
          timer_d    = TIMER_W'(1);
        end else if (a_valid && a_mispredict) begin
          i2d_clear = 1'b1;
          d2a_clear = 1'b1;
        end else if (load_use) begin
          pc_retain  = 1'b1;
          i2d_retain = 1'b1;
          d2a_clear  = 1'b1;
        end
      end
    end
  end

  // State and d-cache wait timer registers
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= ST_RUN;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Saturating count of cycles the PC was held outside HALTED
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (pc_retain && !halted && (stall_q != '1)) begin
      stall_q <= stall_q + PERF_W'(1);
    end
  end

  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl. A driver applies one input
// vector per cycle and pushes the reference model's expected response onto
// a scoreboard. A monitor pops that response at the falling edge and
// compares it with the DUT outputs.
module tb_pipeline_hazard_ctrl;

  localparam int MEM_TO = 4;
  localparam int RAW    = 4;
  localparam int PW     = 5;
  localparam int STALL_MAX = (1 << PW) - 1;

  typedef struct packed {
    logic           rst;
    logic           d_valid;
    logic           d_rs_read;
    logic [RAW-1:0] d_rs_addr;
    logic           a_valid;
    logic           a_mem_load;
    logic           a_mem_access;
    logic           a_reg_write;
    logic [RAW-1:0] a_reg_addr;
    logic           a_mispredict;
    logic           dc_ready;
    logic           w_valid;
    logic           w_halt;
    logic           w_interrupt;
    logic           resume;
  } in_t;

  typedef struct packed {
    logic          pc_retain;
    logic          i2d_retain;
    logic          i2d_clear;
    logic          d2a_retain;
    logic          d2a_clear;
    logic          a2w_retain;
    logic          a2w_clear;
    logic          halted;
    logic          err;
    logic [PW-1:0] stall;
  } exp_t;

  logic           clk;
  logic           rst;
  logic           d_valid, d_rs_read, a_valid, a_mem_load, a_mem_access;
  logic           a_reg_write, a_mispredict, dc_ready, w_valid, w_halt;
  logic           w_interrupt, resume;
  logic [RAW-1:0] d_rs_addr, a_reg_addr;
  logic           pc_retain, i2d_retain, i2d_clear, d2a_retain, d2a_clear;
  logic           a2w_retain, a2w_clear, halted, mem_timeout_err;
  logic [PW-1:0]  stall_cycles;

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT(MEM_TO),
    .REG_ADDR_W (RAW),
    .PERF_W     (PW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .d_valid        (d_valid),
    .d_rs_read      (d_rs_read),
    .d_rs_addr      (d_rs_addr),
    .a_valid        (a_valid),
    .a_mem_load     (a_mem_load),
    .a_mem_access   (a_mem_access),
    .a_reg_write    (a_reg_write),
    .a_reg_addr     (a_reg_addr),
    .a_mispredict   (a_mispredict),
    .dc_ready       (dc_ready),
    .w_valid        (w_valid),
    .w_halt         (w_halt),
    .w_interrupt    (w_interrupt),
    .resume         (resume),
    .pc_retain      (pc_retain),
    .i2d_retain     (i2d_retain),
    .i2d_clear      (i2d_clear),
    .d2a_retain     (d2a_retain),
    .d2a_clear      (d2a_clear),
    .a2w_retain     (a2w_retain),
    .a2w_clear      (a2w_clear),
    .halted         (halted),
    .mem_timeout_err(mem_timeout_err),
    .stall_cycles   (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  // Reference model: the pipeline is either running, waiting on the d-cache
  // (with the number of wait cycles seen so far), or halted.
  localparam int M_RUN = 0, M_WAIT = 1, M_HALT = 2;
  int mode      = M_RUN;
  int wait_cnt  = 0;
  int stall_cnt = 0;

  task automatic flush_all(inout exp_t e);
    e.i2d_clear = 1'b1;
    e.d2a_clear = 1'b1;
    e.a2w_clear = 1'b1;
  endtask

  task automatic hold_for_dcache(inout exp_t e);
    e.pc_retain  = 1'b1;
    e.i2d_retain = 1'b1;
    e.d2a_retain = 1'b1;
    e.a2w_clear  = 1'b1;
  endtask

  task automatic apply_rules(input in_t x, input bit miss_ok, inout exp_t e);
    if (x.w_valid && (x.w_halt || x.w_interrupt)) begin
      flush_all(e);
      if (x.w_halt) mode = M_HALT;
    end else if (miss_ok && x.a_valid && x.a_mem_access && !x.dc_ready) begin
      hold_for_dcache(e);
      mode     = M_WAIT;
      wait_cnt = 1;
    end else if (x.a_valid && x.a_mispredict) begin
      e.i2d_clear = 1'b1;
      e.d2a_clear = 1'b1;
    end else if (x.d_valid && x.d_rs_read && x.a_valid && x.a_mem_load &&
                 x.a_reg_write && (x.d_rs_addr == x.a_reg_addr)) begin
      e.pc_retain  = 1'b1;
      e.i2d_retain = 1'b1;
      e.d2a_clear  = 1'b1;
    end
  endtask

  task automatic model(input in_t x, output exp_t e);
    e = '0;
    if (x.rst) begin
      mode      = M_RUN;
      wait_cnt  = 0;
      stall_cnt = 0;
      flush_all(e);
      return;
    end
    e.stall = PW'(stall_cnt);
    case (mode)
      M_HALT: begin
        e.pc_retain = 1'b1;
        e.halted    = 1'b1;
        flush_all(e);
        if (x.resume) mode = M_RUN;
      end
      M_WAIT: begin
        if (x.dc_ready) begin
          mode = M_RUN;
          apply_rules(x, 1'b0, e);
        end else if (wait_cnt < MEM_TO) begin
          hold_for_dcache(e);
          wait_cnt++;
        end else begin
          e.err = 1'b1;
          flush_all(e);
          mode = M_RUN;
        end
      end
      default: apply_rules(x, 1'b1, e);
    endcase
    if (e.pc_retain && !e.halted && stall_cnt < STALL_MAX) stall_cnt++;
  endtask

  task automatic apply(input in_t x);
    rst          = x.rst;
    d_valid      = x.d_valid;
    d_rs_read    = x.d_rs_read;
    d_rs_addr    = x.d_rs_addr;
    a_valid      = x.a_valid;
    a_mem_load   = x.a_mem_load;
    a_mem_access = x.a_mem_access;
    a_reg_write  = x.a_reg_write;
    a_reg_addr   = x.a_reg_addr;
    a_mispredict = x.a_mispredict;
    dc_ready     = x.dc_ready;
    w_valid      = x.w_valid;
    w_halt       = x.w_halt;
    w_interrupt  = x.w_interrupt;
    resume       = x.resume;
  endtask

  // One cycle of stimulus; pulse_rst drops a short reset pulse between edges first.
  task automatic drive(input in_t x, input bit pulse_rst);
    exp_t e;
    exp_t dummy;
    in_t  r;
    @(posedge clk);
    #1;
    if (pulse_rst) begin
      r     = x;
      r.rst = 1'b1;
      apply(r);
      model(r, dummy);
      #1;
    end
    apply(x);
    model(x, e);
    sb.push_back(e);
  endtask

  function automatic in_t idle();
    in_t x;
    x          = '0;
    x.dc_ready = 1'b1;
    return x;
  endfunction

  function automatic in_t load_at_a(input int dst);
    in_t x;
    x              = idle();
    x.a_valid      = 1'b1;
    x.a_mem_load   = 1'b1;
    x.a_mem_access = 1'b1;
    x.a_reg_write  = 1'b1;
    x.a_reg_addr   = RAW'(dst);
    return x;
  endfunction

  function automatic in_t read_at_d(input in_t base, input int src);
    in_t x;
    x           = base;
    x.d_valid   = 1'b1;
    x.d_rs_read = 1'b1;
    x.d_rs_addr = RAW'(src);
    return x;
  endfunction

  // Monitor: compare the DUT against the oldest expected response
  initial begin
    exp_t e;
    logic [8:0] got_ctl;
    logic [8:0] exp_ctl;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e       = sb.pop_front();
        got_ctl = {pc_retain, i2d_retain, i2d_clear, d2a_retain, d2a_clear,
                   a2w_retain, a2w_clear, halted, mem_timeout_err};
        exp_ctl = {e.pc_retain, e.i2d_retain, e.i2d_clear, e.d2a_retain, e.d2a_clear,
                   e.a2w_retain, e.a2w_clear, e.halted, e.err};
        checks++;
        if (got_ctl !== exp_ctl) begin
          errors++;
          $display("FAIL ctl t=%0t got=%b expected=%b (pc,i2d_r,i2d_c,d2a_r,d2a_c,a2w_r,a2w_c,halted,err)",
                   $time, got_ctl, exp_ctl);
        end
        checks++;
        if (stall_cycles !== e.stall) begin
          errors++;
          $display("FAIL stall_cycles t=%0t got=%0d expected=%0d", $time, stall_cycles, e.stall);
        end
      end
    end
  end

  initial begin
    in_t x;
    apply(idle());
    rst = 1'b1;

    // Reset state
    x = idle(); x.rst = 1'b1;
    drive(x, 1'b0);
    drive(x, 1'b0);
    drive(idle(), 1'b0);

    // Load-use hit, then the same load with a different decode source
    drive(read_at_d(load_at_a(3), 3), 1'b0);
    drive(idle(), 1'b0);
    drive(read_at_d(load_at_a(3), 4), 1'b0);
    drive(idle(), 1'b0);

    // Load with dc_ready low for three cycles, released on the fourth
    x = load_at_a(5); x.dc_ready = 1'b0;
    repeat (3) drive(x, 1'b0);
    x.dc_ready = 1'b1;
    drive(x, 1'b0);
    drive(idle(), 1'b0);

    // d-cache never answers: timeout abort
    x = load_at_a(6); x.dc_ready = 1'b0;
    repeat (6) drive(x, 1'b0);
    drive(idle(), 1'b0);

    // Mispredict together with a load-use hazard
    x = read_at_d(load_at_a(2), 2); x.a_mispredict = 1'b1;
    drive(x, 1'b0);
    drive(idle(), 1'b0);

    // Halt at writeback with a mispredict at act, then resume
    x = idle(); x.a_valid = 1'b1; x.a_mispredict = 1'b1; x.w_valid = 1'b1; x.w_halt = 1'b1;
    drive(x, 1'b0);
    repeat (2) drive(idle(), 1'b0);
    x = idle(); x.resume = 1'b1;
    drive(x, 1'b0);
    drive(idle(), 1'b0);

    // Interrupt at writeback keeps running
    x = idle(); x.w_valid = 1'b1; x.w_interrupt = 1'b1;
    drive(x, 1'b0);
    drive(idle(), 1'b0);

    // Reset pulse between edges while waiting on the d-cache
    x = load_at_a(7); x.dc_ready = 1'b0;
    repeat (2) drive(x, 1'b0);
    drive(x, 1'b1);
    drive(idle(), 1'b0);

    // Reset held across an edge while waiting on the d-cache
    x = load_at_a(7); x.dc_ready = 1'b0;
    repeat (2) drive(x, 1'b0);
    x.rst = 1'b1;
    drive(x, 1'b0);
    drive(idle(), 1'b0);

    // Reset pulse while halted
    x = idle(); x.w_valid = 1'b1; x.w_halt = 1'b1;
    drive(x, 1'b0);
    drive(idle(), 1'b0);
    drive(idle(), 1'b1);
    drive(idle(), 1'b0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      x              = '0;
      x.d_valid      = ($urandom_range(0, 3) != 0);
      x.d_rs_read    = ($urandom_range(0, 3) != 0);
      x.d_rs_addr    = RAW'($urandom_range(0, 3));
      x.a_valid      = ($urandom_range(0, 3) != 0);
      x.a_mem_load   = $urandom_range(0, 1) != 0;
      x.a_mem_access = x.a_mem_load | ($urandom_range(0, 3) == 0);
      x.a_reg_write  = ($urandom_range(0, 3) != 0);
      x.a_reg_addr   = RAW'($urandom_range(0, 3));
      x.a_mispredict = ($urandom_range(0, 5) == 0);
      x.dc_ready     = ($urandom_range(0, 9) < 6);
      x.w_valid      = (mode != M_WAIT) && ($urandom_range(0, 1) != 0);
      x.w_halt       = ($urandom_range(0, 24) == 0);
      x.w_interrupt  = ($urandom_range(0, 19) == 0);
      x.resume       = ($urandom_range(0, 3) == 0);
      x.rst          = ($urandom_range(0, 299) == 0);
      drive(x, $urandom_range(0, 299) == 0);
    end
    drive(idle(), 1'b0);

    // Let the monitor drain the scoreboard, bounded
    for (int c = 0; c < 10 && sb.size() > 0; c++) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
